// File: rtl/fault_supervisor_n.sv
// -----------------------------------------------------------------------------
// fault_supervisor_n
//
// N-channel fault supervisor. Each unmasked fault input has a persistence
// counter; long enough persistence escalates the supervisor one step per
// clock along NORMAL -> WARNING -> FAULT -> SHUTDOWN. WARNING/FAULT return to
// NORMAL on an operator acknowledge or, optionally, after a clean interval.
// SHUTDOWN is left only by an explicit operator release with all channels
// quiet.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           asynchronous, active-low reset
//   fault_in        raw per-channel fault flags (synchronous to clk)
//   mask            1 = ignore that channel
//   clear_warning   operator acknowledge (WARNING/FAULT -> NORMAL, sticky clear)
//   shutdown_clear  operator release from SHUTDOWN
//   state           registered FSM state (00 NORMAL, 01 WARNING, 10 FAULT,
//                   11 SHUTDOWN); doubles as the FSM debug view
//   warn/fault/shutdown  one-hot decode of the registered state
//   active_fault_id combinational highest active channel index + 1, 0 = none
//   first_fault_id  channel that caused the latest NORMAL -> WARNING step
//   fault_sticky    per-channel "has been active" flags
//
// There is no valid/ready handshake on this block: every input is a level
// sampled on each rising edge and every output is a level.
// -----------------------------------------------------------------------------
module fault_supervisor_n #(
   parameter int N_CH         = 4,
   parameter int ID_W         = 4,
   parameter int CNT_W        = 8,
   parameter int P_WARN       = 5,
   parameter int P_FAULT      = 12,
   parameter int P_SHUT       = 30,
   parameter int AUTO_RECOVER = 0,
   parameter int P_RECOVER    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   fault_in,
   input  logic [N_CH-1:0]   mask,
   input  logic              clear_warning,
   input  logic              shutdown_clear,
   output logic [1:0]        state,
   output logic              warn,
   output logic              fault,
   output logic              shutdown,
   output logic [ID_W-1:0]   active_fault_id,
   output logic [ID_W-1:0]   first_fault_id,
   output logic [N_CH-1:0]   fault_sticky
);

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'b00,
      ST_WARNING  = 2'b01,
      ST_FAULT    = 2'b10,
      ST_SHUTDOWN = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TH_WARN    = CNT_W'(P_WARN);
   localparam logic [CNT_W-1:0] TH_FAULT   = CNT_W'(P_FAULT);
   localparam logic [CNT_W-1:0] TH_SHUT    = CNT_W'(P_SHUT);
   // clean_q holds the number of clean edges already seen, so the edge that
   // completes the interval is the one where clean_q reaches P_RECOVER-1.
   localparam logic [CNT_W-1:0] TH_RECOVER = CNT_W'(P_RECOVER - 1);

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt_q [N_CH];
   logic [CNT_W-1:0]  clean_q;
   logic [N_CH-1:0]   act;
   logic              any_active;
   logic              warn_cond;
   logic              fault_cond;
   logic              shut_cond;
   logic              auto_ok;
   logic              recover_ok;
   logic              sd_exit;
   logic [N_CH-1:0]   sticky_clr;

   assign act        = fault_in & ~mask;
   assign any_active = |act;

   // Ascending scan so the highest active index is the last one written.
   always_comb begin
      active_fault_id = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (act[i]) active_fault_id = ID_W'(i + 1);
      end
   end

   // Level conditions use the registered count, which is why a channel high
   // from edge 1 first meets P_WARN on edge P_WARN+1.
   always_comb begin
      warn_cond  = 1'b0;
      fault_cond = 1'b0;
      shut_cond  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (act[i] && (cnt_q[i] >= TH_WARN))  warn_cond  = 1'b1;
         if (act[i] && (cnt_q[i] >= TH_FAULT)) fault_cond = 1'b1;
         if (act[i] && (cnt_q[i] >= TH_SHUT))  shut_cond  = 1'b1;
      end
   end

   assign auto_ok    = (AUTO_RECOVER != 0) && (clean_q >= TH_RECOVER);
   assign recover_ok = !any_active && (clear_warning || auto_ok);
   assign sd_exit    = (state_q == ST_SHUTDOWN) && shutdown_clear && !any_active;

   // Next-state logic: at most one escalation step per edge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_NORMAL: begin
            if (warn_cond) state_d = ST_WARNING;
         end
         ST_WARNING: begin
            if (fault_cond)      state_d = ST_FAULT;
            else if (recover_ok) state_d = ST_NORMAL;
         end
         ST_FAULT: begin
            if (shut_cond)       state_d = ST_SHUTDOWN;
            else if (recover_ok) state_d = ST_NORMAL;
         end
         ST_SHUTDOWN: begin
            if (sd_exit) state_d = ST_NORMAL;
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_NORMAL;
      else        state_q <= state_d;
   end

   // Persistence counters: any inactive edge restarts the count, saturate at max.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (sd_exit || !act[i])       cnt_q[i] <= '0;
            else if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Clean-interval counter only runs while in WARNING/FAULT with all quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clean_q <= '0;
      end else if (any_active || (state_q == ST_NORMAL) || (state_q == ST_SHUTDOWN)) begin
         clean_q <= '0;
      end else if (clean_q != CNT_MAX) begin
         clean_q <= clean_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_fault_id <= '0;
      end else if (state_d == ST_NORMAL) begin
         first_fault_id <= '0;
      end else if ((state_q == ST_NORMAL) && (state_d == ST_WARNING)) begin
         first_fault_id <= active_fault_id;
      end
   end

   // Acknowledge in NORMAL clears quiet channels; an active channel re-sets
   // its flag on the same edge, so set wins over clear.
   assign sticky_clr = ((state_q == ST_NORMAL) && clear_warning) ? ~act : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fault_sticky <= '0;
      else        fault_sticky <= act | (fault_sticky & ~sticky_clr);
   end

   assign state    = state_q;
   assign warn     = (state_q == ST_WARNING);
   assign fault    = (state_q == ST_FAULT);
   assign shutdown = (state_q == ST_SHUTDOWN);

endmodule

// File: tb/tb_fault_supervisor_n.sv
// -----------------------------------------------------------------------------
// tb_fault_supervisor_n
//
// Directed bench for fault_supervisor_n. Three instances share the stimulus:
//   u_dut  default parameters (AUTO_RECOVER = 0)
//   u_ar   AUTO_RECOVER = 1, P_RECOVER = 8
//   u_sat  CNT_W = 5, P_SHUT = 31 (counter saturation)
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// so "after edge k" means after k rising edges with the stimulus applied.
// -----------------------------------------------------------------------------
module tb_fault_supervisor_n;

   localparam int N_CH = 4;
   localparam int ID_W = 4;

   logic              clk;
   logic              rst_n;
   logic [N_CH-1:0]   fault_in;
   logic [N_CH-1:0]   mask;
   logic              clear_warning;
   logic              shutdown_clear;

   logic [1:0]        d_state,  a_state,  s_state;
   logic              d_warn,   a_warn,   s_warn;
   logic              d_fault,  a_fault,  s_fault;
   logic              d_shut,   a_shut,   s_shut;
   logic [ID_W-1:0]   d_act_id, a_act_id, s_act_id;
   logic [ID_W-1:0]   d_first,  a_first,  s_first;
   logic [N_CH-1:0]   d_sticky, a_sticky, s_sticky;

   int n_checks;
   int n_errors;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   fault_supervisor_n #(.N_CH(N_CH), .ID_W(ID_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .fault_in(fault_in), .mask(mask),
      .clear_warning(clear_warning), .shutdown_clear(shutdown_clear),
      .state(d_state), .warn(d_warn), .fault(d_fault), .shutdown(d_shut),
      .active_fault_id(d_act_id), .first_fault_id(d_first), .fault_sticky(d_sticky)
   );

   fault_supervisor_n #(.N_CH(N_CH), .ID_W(ID_W), .AUTO_RECOVER(1), .P_RECOVER(8)) u_ar (
      .clk(clk), .rst_n(rst_n), .fault_in(fault_in), .mask(mask),
      .clear_warning(clear_warning), .shutdown_clear(shutdown_clear),
      .state(a_state), .warn(a_warn), .fault(a_fault), .shutdown(a_shut),
      .active_fault_id(a_act_id), .first_fault_id(a_first), .fault_sticky(a_sticky)
   );

   fault_supervisor_n #(.N_CH(N_CH), .ID_W(ID_W), .CNT_W(5), .P_SHUT(31)) u_sat (
      .clk(clk), .rst_n(rst_n), .fault_in(fault_in), .mask(mask),
      .clear_warning(clear_warning), .shutdown_clear(shutdown_clear),
      .state(s_state), .warn(s_warn), .fault(s_fault), .shutdown(s_shut),
      .active_fault_id(s_act_id), .first_fault_id(s_first), .fault_sticky(s_sticky)
   );

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      rst_n          = 1'b0;
      fault_in       = '0;
      mask           = '0;
      clear_warning  = 1'b0;
      shutdown_clear = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic check_main(input string tag, input logic [1:0] st,
                             input logic [ID_W-1:0] first, input logic [N_CH-1:0] sticky);
      check({tag, ".state"},  32'(d_state),  32'(st));
      check({tag, ".warn"},   32'(d_warn),   32'(st == 2'b01));
      check({tag, ".fault"},  32'(d_fault),  32'(st == 2'b10));
      check({tag, ".shut"},   32'(d_shut),   32'(st == 2'b11));
      check({tag, ".first"},  32'(d_first),  32'(first));
      check({tag, ".sticky"}, 32'(d_sticky), 32'(sticky));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;

      // Reset values, plus active id following inputs during reset.
      rst_n = 1'b0; fault_in = 4'b0100; mask = '0;
      clear_warning = 1'b0; shutdown_clear = 1'b0;
      #3;
      check_main("rst", 2'b00, 4'd0, 4'b0000);
      check("rst.act_id", 32'(d_act_id), 32'd3);

      // T1: channel 0 held high; escalation timing.
      apply_reset();
      fault_in = 4'b0001;
      step(5);
      check_main("t1.e5", 2'b00, 4'd0, 4'b0001);
      step(1);
      check_main("t1.e6", 2'b01, 4'd1, 4'b0001);
      step(6);
      check_main("t1.e12", 2'b01, 4'd1, 4'b0001);
      step(1);
      check_main("t1.e13", 2'b10, 4'd1, 4'b0001);
      step(17);
      check_main("t1.e30", 2'b10, 4'd1, 4'b0001);
      step(1);
      check_main("t1.e31", 2'b11, 4'd1, 4'b0001);
      check("t1.sat.e31", 32'(s_state), 32'd2);
      step(1);
      check("t1.sat.e32", 32'(s_state), 32'd3);
      step(8);
      check_main("t1.e40", 2'b11, 4'd1, 4'b0001);
      // clear_warning does nothing in SHUTDOWN.
      fault_in = 4'b0000; clear_warning = 1'b1;
      step(1);
      check_main("t1.cw_sd", 2'b11, 4'd1, 4'b0001);
      // Release attempt with fault still active is refused.
      fault_in = 4'b0001; clear_warning = 1'b0; shutdown_clear = 1'b1;
      step(1);
      check_main("t1.sdc_act", 2'b11, 4'd1, 4'b0001);
      fault_in = 4'b0000;
      step(1);
      check_main("t1.sdc_ok", 2'b00, 4'd0, 4'b0001);
      shutdown_clear = 1'b0; clear_warning = 1'b1;
      step(1);
      check_main("t1.stk_clr", 2'b00, 4'd0, 4'b0000);
      // Counters restart from zero after the release.
      clear_warning = 1'b0; fault_in = 4'b0001;
      step(5);
      check("t1.re.e5", 32'(d_state), 32'd0);
      step(1);
      check("t1.re.e6", 32'(d_state), 32'd1);

      // T2: channels 1 and 3 together, drop 3 at cycle 8.
      apply_reset();
      fault_in = 4'b1010;
      #1;
      check("t2.act_id4", 32'(d_act_id), 32'd4);
      step(6);
      check_main("t2.e6", 2'b01, 4'd4, 4'b1010);
      step(2);
      fault_in = 4'b0010;
      #1;
      check("t2.act_id2", 32'(d_act_id), 32'd2);
      step(4);
      check_main("t2.e12", 2'b01, 4'd4, 4'b1010);
      step(1);
      check_main("t2.e13", 2'b10, 4'd4, 4'b1010);
      // Acknowledge ignored while a channel is active.
      clear_warning = 1'b1;
      step(1);
      check("t2.cw_act", 32'(d_state), 32'd2);
      // Masking the channel makes it inactive; acknowledge now returns to NORMAL.
      mask = 4'b0010;
      #1;
      check("t2.mask_id", 32'(d_act_id), 32'd0);
      step(1);
      check_main("t2.cw_ok", 2'b00, 4'd0, 4'b1010);
      clear_warning = 1'b0; mask = 4'b0000;

      // T3: channel 2 for 10 cycles, manual clear only.
      apply_reset();
      fault_in = 4'b0100;
      step(10);
      check_main("t3.e10", 2'b01, 4'd3, 4'b0100);
      fault_in = 4'b0000;
      step(20);
      check_main("t3.hold", 2'b01, 4'd3, 4'b0100);
      check("t3.ar", 32'(a_state), 32'd0);
      clear_warning = 1'b1;
      step(1);
      check_main("t3.cw", 2'b00, 4'd0, 4'b0100);
      clear_warning = 1'b0;

      // T4: auto-recovery from FAULT with a glitch restarting the interval.
      apply_reset();
      fault_in = 4'b0001;
      step(13);
      check("t4.fault", 32'(a_state), 32'd2);
      check("t4.first", 32'(a_first), 32'd1);
      fault_in = 4'b0000;
      step(4);
      check("t4.clean4", 32'(a_state), 32'd2);
      fault_in = 4'b0001;
      step(1);
      fault_in = 4'b0000;
      step(7);
      check("t4.clean7", 32'(a_state), 32'd2);
      check("t4.main7", 32'(d_state), 32'd2);
      step(1);
      check("t4.clean8", 32'(a_state), 32'd0);
      check("t4.first0", 32'(a_first), 32'd0);
      check("t4.warn0", 32'(a_warn), 32'd0);
      check("t4.main8", 32'(d_state), 32'd2);

      // T5: saturation with a 5-bit counter, then async reset mid-run.
      apply_reset();
      fault_in = 4'b0001;
      step(100);
      check("t5.sat.state", 32'(s_state), 32'd3);
      check("t5.sat.cnt", 32'(u_sat.cnt_q[0]), 32'd31);
      check("t5.sat.first", 32'(s_first), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5.rst.state", 32'(s_state), 32'd0);
      check("t5.rst.shut", 32'(s_shut), 32'd0);
      check("t5.rst.first", 32'(s_first), 32'd0);
      check("t5.rst.sticky", 32'(s_sticky), 32'd0);
      check("t5.rst.cnt", 32'(u_sat.cnt_q[0]), 32'd0);
      check_main("t5.rst", 2'b00, 4'd0, 4'b0000);
      check("t5.rst.act_id", 32'(d_act_id), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fault_supervisor_n.md
# fault_supervisor_n

Parametrised N-channel fault supervisor with escalation NORMAL → WARNING → FAULT → SHUTDOWN, driven by per-channel persistence counters. It adds four things: configurable channel count and counter width, optional automatic recovery after a clean interval, a latched first-fault cause with per-channel sticky flags, and an operator-controlled exit from SHUTDOWN. It sits between the analog comparator/monitor synchronisers and the power-stage enable logic.

## Interface
- N_CH, 4: number of fault channels (1..15).
- ID_W, 4: fault-id width. Requires 2^ID_W > N_CH.
- CNT_W, 8: persistence/clean counter width. Counters saturate at 2^CNT_W−1.
- P_WARN, 5: persistence threshold for WARNING.
- P_FAULT, 12: persistence threshold for FAULT.
- P_SHUT, 30: persistence threshold for SHUTDOWN. Requires P_WARN < P_FAULT < P_SHUT ≤ 2^CNT_W−1.
- AUTO_RECOVER, 0: 1 enables timed return to NORMAL.
- P_RECOVER, 8: consecutive clean cycles needed for auto-recovery (≤ 2^CNT_W−1).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fault_in  in  N_CH  raw fault flags, synchronous to clk.
- mask  in  N_CH  1 = ignore channel.
- clear_warning  in  1  operator acknowledge.
- shutdown_clear  in  1  operator release from SHUTDOWN.
- state  out  2  00 NORMAL, 01 WARNING, 10 FAULT, 11 SHUTDOWN.
- warn, fault, shutdown  out  1 each  one-hot decode of state.
- active_fault_id  out  ID_W  combinational highest-priority active channel, index+1; 0 = none.
- first_fault_id  out  ID_W  registered cause of the latest NORMAL→WARNING escalation.
- fault_sticky  out  N_CH  registered per-channel "has been active" flags.

## Operation
- Active channel: a[i] = fault_in[i] & ~mask[i].
- Priority: the highest index wins.
- cnt[i] (registered) on each edge:
  - a[i] = 1: cnt[i] = min(cnt[i]+1, max). Saturates and never wraps.
  - a[i] = 0: cnt[i] = 0. Masking a channel mid-count also clears it.
- Level-L condition: some i has a[i] = 1 and cnt[i] ≥ P_L. Only one state step per edge, even when a higher threshold is also met.
- clean_cnt (registered):
  - Clears to 0 whenever any a[i] = 1 or state is NORMAL/SHUTDOWN.
  - Otherwise increments, saturating.
- Transitions, evaluated on each edge:
  - NORMAL → WARNING on the WARN condition.
  - WARNING → FAULT on the FAULT condition.
  - FAULT → SHUTDOWN on the SHUT condition.
  - WARNING/FAULT → NORMAL when no a[i] is set and either clear_warning = 1, or AUTO_RECOVER = 1 with clean_cnt ≥ P_RECOVER−1 (i.e. the P_RECOVER-th clean edge).
  - While any a[i] = 1, clear_warning is ignored in WARNING/FAULT.
  - SHUTDOWN → NORMAL only when shutdown_clear = 1 and no a[i] is set. Otherwise SHUTDOWN holds; clear_warning has no effect there. On this exit all cnt[i] are cleared.
- first_fault_id:
  - Loads active_fault_id on the NORMAL→WARNING edge.
  - Clears to 0 on any edge entering NORMAL.
  - Holds otherwise.
- fault_sticky[i]:
  - Sets on any edge with a[i] = 1.
  - Clears on an edge where state = NORMAL, clear_warning = 1 and a[i] = 0. If set and clear coincide, set wins.
- warn/fault/shutdown are decoded from the registered state only; they never depend on inputs combinationally.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge):
  - state = NORMAL; warn = fault = shutdown = 0.
  - All cnt[i] and clean_cnt = 0.
  - first_fault_id = 0, fault_sticky = 0.
  - active_fault_id follows inputs combinationally even during reset.
- A channel held high from edge 1 gives cnt = k after edge k. state = WARNING after edge P_WARN+1, FAULT after edge P_FAULT+1, SHUTDOWN after edge P_SHUT+1.
- A one-cycle drop of the input restarts the count; there is no partial credit.
- Manual clear: clear_warning is sampled on the same edge that returns to NORMAL; warn deasserts 1 cycle later.
- Auto-recovery: state = NORMAL after the P_RECOVER-th consecutive clean edge.
- Reset asserted mid-escalation returns to NORMAL immediately. There is no recovery delay.

## Test plan
- N_CH = 4, channel 0 held high 40 cycles, defaults: WARNING after edge 6, FAULT after edge 13, SHUTDOWN after edge 31; first_fault_id = 1 throughout; fault_sticky = 0001.
- Channels 1 and 3 raised together: active_fault_id = 4. Drop channel 3 at cycle 8: id = 2, state stays WARNING (entered at edge 6 via either channel), channel 1 continues to FAULT at edge 13.
- Channel 2 high for 10 cycles then low, AUTO_RECOVER = 0: state holds WARNING until clear_warning pulses; NORMAL on that edge, first_fault_id → 0.
- AUTO_RECOVER = 1, P_RECOVER = 8, fault removed while in FAULT: NORMAL after the 8th clean edge. A glitch at clean cycle 5 restarts the interval.
- In SHUTDOWN, shutdown_clear pulses with a fault still active: no exit. Remove the fault, pulse again: NORMAL next edge, all cnt = 0.
- CNT_W = 5, P_SHUT = 31, fault held 100 cycles: cnt saturates at 31 with no wrap and state stays SHUTDOWN. Assert rst_n low mid-run: all outputs at reset values asynchronously.
